// File: rtl/frame_transmitter.sv
// Serial framer: one-deep holding register feeding a shifter that sends SFD then payload, LSB-first, on tx.
// Accept-to-first-SFD-bit latency is one cycle from IDLE; ready is a pure register decode.
module frame_transmitter #(
  parameter int                       data_pack_len = 8,
  parameter int                       sfd_len_limit = 8,
  parameter logic [sfd_len_limit-1:0] sfd           = 8'b11010101,
  parameter int                       idle_gap      = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [data_pack_len-1:0] din,
  input  logic                     load,
  output logic                     ready,
  output logic                     tx,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int CNT_W = 4;
  localparam int SIW   = $clog2(sfd_len_limit);
  localparam int DIW   = $clog2(data_pack_len);
  localparam logic [CNT_W-1:0] SFD_LAST  = CNT_W'(sfd_len_limit);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(data_pack_len);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(idle_gap);

  typedef enum logic [1:0] {
    IDLE,
    SFD,
    DATA,
    GAP
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         cnt_nxt;
  logic [CNT_W-1:0]         gap_cnt;
  logic [CNT_W-1:0]         gap_cnt_nxt;
  logic [data_pack_len-1:0] shreg;
  logic [data_pack_len-1:0] hold;
  logic                     hold_full;
  logic                     tx_nxt;
  logic                     frame_done_nxt;
  logic                     consume;

  assign ready = ~hold_full;
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    gap_cnt_nxt    = gap_cnt;
    tx_nxt         = 1'b0;
    frame_done_nxt = 1'b0;
    consume        = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          consume   = 1'b1;
          tx_nxt    = sfd[0];
          cnt_nxt   = 4'd1;
          state_nxt = SFD;
        end
      end
      SFD: begin
        // cnt has reached the SFD length once its last bit is on the line
        if (cnt == SFD_LAST) begin
          tx_nxt    = shreg[0];
          cnt_nxt   = 4'd1;
          state_nxt = DATA;
        end else begin
          tx_nxt  = sfd[cnt[SIW-1:0]];
          cnt_nxt = cnt + 4'd1;
        end
      end
      DATA: begin
        if (cnt == DATA_LAST) begin
          frame_done_nxt = 1'b1;
          gap_cnt_nxt    = 4'd1;
          cnt_nxt        = '0;
          state_nxt      = GAP;
        end else begin
          tx_nxt  = shreg[cnt[DIW-1:0]];
          cnt_nxt = cnt + 4'd1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_cnt_nxt = '0;
          if (hold_full) begin
            consume   = 1'b1;
            tx_nxt    = sfd[0];
            cnt_nxt   = 4'd1;
            state_nxt = SFD;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          gap_cnt_nxt = gap_cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      gap_cnt    <= '0;
      tx         <= 1'b0;
      frame_done <= 1'b0;
      shreg      <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      gap_cnt    <= gap_cnt_nxt;
      tx         <= tx_nxt;
      frame_done <= frame_done_nxt;
      // consume only happens with ready low, so it never races an accept
      if (consume) begin
        shreg     <= hold;
        hold_full <= 1'b0;
      end else if (load && ready) begin
        hold      <= din;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_transmitter.sv
// Scoreboarded bench: accepted bytes are queued, a monitor deframes tx and compares.
module tb_frame_transmitter;

  localparam int         IDLE_GAP = 2;
  localparam logic [7:0] SFD_VAL  = 8'b11010101;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] din = 8'h00;
  logic       load = 1'b0;
  logic       ready, tx, busy, frame_done;

  logic [7:0] din1 = 8'h00;
  logic       load1 = 1'b0;
  logic       ready1, tx1, busy1, frame_done1;

  frame_transmitter #(.idle_gap(IDLE_GAP)) dut (
    .clk(clk), .reset(reset), .din(din), .load(load),
    .ready(ready), .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  frame_transmitter #(.idle_gap(1)) dut1 (
    .clk(clk), .reset(reset), .din(din1), .load(load1),
    .ready(ready1), .tx(tx1), .busy(busy1), .frame_done(frame_done1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: hunt for the first 1 (sfd[0]), collect 16 bits, then expect frame_done.
  int          mon_st = 0;
  int          nbits = 0;
  int          zeros = 0;
  int          last_gap = 0;
  bit          have_prev = 1'b0;
  logic [15:0] bits = '0;
  logic [7:0]  exp_b;

  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      mon_st    = 0;
      zeros     = 0;
      have_prev = 1'b0;
    end else begin
      if (mon_st != 2) chk("frame_done_spurious", frame_done, 1'b0);
      case (mon_st)
        0: begin
          if (tx) begin
            if (have_prev) chk("gap_min", zeros >= IDLE_GAP, 1'b1);
            last_gap = zeros;
            bits     = '0;
            bits[0]  = 1'b1;
            nbits    = 1;
            mon_st   = 1;
          end else if (zeros < 1000) begin
            zeros++;
          end
        end
        1: begin
          bits[nbits] = tx;
          nbits++;
          if (nbits == 16) begin
            chk("sfd_bits", bits[7:0], SFD_VAL);
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_frame: got data %0h, expected no frame", bits[15:8]);
            end else begin
              exp_b = exp_q.pop_front();
              chk("frame_data", bits[15:8], exp_b);
            end
            mon_st = 2;
          end
        end
        default: begin
          chk("frame_done_pulse", {frame_done, tx}, 2'b10);
          zeros     = 1;
          have_prev = 1'b1;
          mon_st    = 0;
        end
      endcase
    end
  end

  task automatic send_random(input int n);
    int sent = 0;
    int guard = 0;
    while (sent < n && guard < 20000) begin
      @(negedge clk);
      guard++;
      load = ($urandom_range(0, 2) != 0);
      din  = 8'($urandom);
      if (load && ready) begin
        exp_q.push_back(din);
        sent++;
      end
    end
    @(negedge clk);
    load = 1'b0;
    chk("send_budget", sent, n);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || busy || !ready) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", t < 3000, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  // Accept a byte at the coming edge; returns positioned just after that edge (negedge).
  task automatic accept(input logic [7:0] b);
    @(negedge clk);
    din  = b;
    load = 1'b1;
    exp_q.push_back(b);
    @(negedge clk);
    load = 1'b0;
    din  = 8'($urandom);
  endtask

  task automatic single_frame();
    logic [15:0] seq;
    seq = {8'hA5, SFD_VAL};
    accept(8'hA5);
    chk("a5_ready_after_accept", ready, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("a5_bit", tx, seq[k-1]);
      if (k == 1) chk("a5_refill_ready", ready, 1'b1);
    end
    @(negedge clk);
    chk("a5_done", {tx, frame_done, busy}, 3'b011);
    for (int k = 18; k < 17 + IDLE_GAP; k++) begin
      @(negedge clk);
      chk("a5_gap_busy", {tx, frame_done, busy}, 3'b001);
    end
    @(negedge clk);
    chk("a5_busy_drop", busy, 1'b0);
  endtask

  task automatic back_to_back();
    accept(8'h12);
    repeat (11) @(negedge clk);
    din  = 8'h34;
    load = 1'b1;
    exp_q.push_back(8'h34);
    @(negedge clk);
    for (int k = 12; k <= 18; k++) begin
      chk("b2b_ready_low", ready, 1'b0);
      if (k < 18) din = 8'($urandom);
      else load = 1'b0;
      @(negedge clk);
    end
    chk("b2b_handover_ready", ready, 1'b1);
    chk("b2b_handover_sfd0", tx, 1'b1);
    wait_idle();
    chk("b2b_gap_exact", last_gap, IDLE_GAP);
  endtask

  task automatic reset_mid_frame();
    accept(8'h5A);
    repeat (2) @(negedge clk);
    din  = 8'hE7;
    load = 1'b1;
    exp_q.push_back(8'hE7);
    @(negedge clk);
    load = 1'b0;
    repeat (11) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_async_tx", tx, 1'b0);
    chk("rst_async_busy", busy, 1'b0);
    chk("rst_async_ready", ready, 1'b1);
    chk("rst_async_fd", frame_done, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      chk("post_rst_quiet", {tx, busy, ready}, 3'b001);
    end
  endtask

  task automatic gap1_stream();
    logic [16:0] pat;
    int t = 0;
    pat = {1'b0, 8'hC3, SFD_VAL};
    @(negedge clk);
    din1  = 8'hC3;
    load1 = 1'b1;
    while (!tx1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("gap1_start", tx1, 1'b1);
    for (int i = 0; i < 5 * 17; i++) begin
      chk("gap1_tx", tx1, pat[i % 17]);
      chk("gap1_frame_done", frame_done1, (i % 17) == 16);
      @(negedge clk);
    end
    load1 = 1'b0;
    repeat (60) @(negedge clk);
    chk("gap1_idle", {busy1, ready1, tx1}, 3'b010);
  endtask

  initial begin
    #1;
    chk("reset_tx", tx, 1'b0);
    chk("reset_ready", ready, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_fd", frame_done, 1'b0);
    chk("reset_dut1", {tx1, ready1, busy1, frame_done1}, 4'b0100);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("idle_no_load", {tx, ready, busy}, 3'b010);
    end
    single_frame();
    wait_idle();
    back_to_back();
    send_random(40);
    wait_idle();
    reset_mid_frame();
    send_random(25);
    wait_idle();
    gap1_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
